// File: rtl/terminal_input_conditioner.sv
// Input stage for two terminals: synchronise and debounce switches/buttons, then
// turn each debounced button press into one held {hh,b} command with a valid/ack handshake.
module terminal_input_conditioner #(
    parameter int   DEB_CYCLES     = 250000,
    parameter int   CNT_W          = 18,
    parameter logic BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hh0_raw,
    input  logic [1:0] b0_raw,
    input  logic [3:0] hh1_raw,
    input  logic [1:0] b1_raw,
    input  logic       cmd_ack0,
    input  logic       cmd_ack1,
    output logic [3:0] hh0,
    output logic [1:0] b0,
    output logic       cmd_valid0,
    output logic [3:0] hh1,
    output logic [1:0] b1,
    output logic       cmd_valid1
);
    localparam int               NB      = 12;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_VALID, ST_RELEASE} state_e;

    // Bit layout of the conditioned vector: [3:0] hh0, [5:4] b0, [9:6] hh1, [11:10] b1.
    logic [1:0]       btn0_norm, btn1_norm;
    logic [NB-1:0]    raw_norm;
    logic [NB-1:0]    sync1_q, sync2_q;
    logic [NB-1:0]    deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [3:0]       btn_prev_q;

    assign btn0_norm = BTN_ACTIVE_LOW ? ~b0_raw : b0_raw;
    assign btn1_norm = BTN_ACTIVE_LOW ? ~b1_raw : b1_raw;
    assign raw_norm  = {btn1_norm, hh1_raw, btn0_norm, hh0_raw};

    // A bit only flips after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            btn_prev_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw_norm;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            btn_prev_q <= {deb_q[11:10], deb_q[5:4]};
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    logic [1:0][3:0] d_hh;
    logic [1:0][1:0] d_btn, press;
    logic [1:0]      ack;

    assign d_hh[0]  = deb_q[3:0];
    assign d_hh[1]  = deb_q[9:6];
    assign d_btn[0] = deb_q[5:4];
    assign d_btn[1] = deb_q[11:10];
    assign press[0] = d_btn[0] & ~btn_prev_q[1:0];
    assign press[1] = d_btn[1] & ~btn_prev_q[3:2];
    assign ack      = {cmd_ack1, cmd_ack0};

    // Handshake: cmd_valid stays high with hh/b frozen until cmd_ack is seen high on a
    // clock edge; that edge clears the command. ack outside VALID has no effect.
    state_e          state_q [2];
    state_e          state_d [2];
    logic [1:0][3:0] hh_q, hh_d;
    logic [1:0][1:0] b_q, b_d;
    logic [1:0]      valid_q, valid_d;

    always_comb begin
        for (int t = 0; t < 2; t++) begin
            state_d[t] = state_q[t];
            hh_d[t]    = hh_q[t];
            b_d[t]     = b_q[t];
            valid_d[t] = valid_q[t];
            case (state_q[t])
                ST_IDLE: begin
                    hh_d[t]    = '0;
                    b_d[t]     = '0;
                    valid_d[t] = 1'b0;
                    if (|press[t]) begin
                        hh_d[t]    = d_hh[t];
                        b_d[t]     = d_btn[t];
                        valid_d[t] = 1'b1;
                        state_d[t] = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (ack[t]) begin
                        hh_d[t]    = '0;
                        b_d[t]     = '0;
                        valid_d[t] = 1'b0;
                        state_d[t] = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Wait for all buttons up so a held button cannot re-issue.
                    hh_d[t]    = '0;
                    b_d[t]     = '0;
                    valid_d[t] = 1'b0;
                    if (d_btn[t] == 2'b00) begin
                        state_d[t] = ST_IDLE;
                    end
                end
                default: begin
                    hh_d[t]    = '0;
                    b_d[t]     = '0;
                    valid_d[t] = 1'b0;
                    state_d[t] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hh_q    <= '0;
            b_q     <= '0;
            valid_q <= '0;
            for (int t = 0; t < 2; t++) begin
                state_q[t] <= ST_IDLE;
            end
        end else begin
            hh_q    <= hh_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            for (int t = 0; t < 2; t++) begin
                state_q[t] <= state_d[t];
            end
        end
    end

    assign hh0        = hh_q[0];
    assign b0         = b_q[0];
    assign cmd_valid0 = valid_q[0];
    assign hh1        = hh_q[1];
    assign b1         = b_q[1];
    assign cmd_valid1 = valid_q[1];

endmodule

// File: tb/tb_terminal_input_conditioner.sv
// Bench for terminal_input_conditioner with a short debounce window: directed corner
// sequences, a vector table, and random stimulus checked against a reference model.
module tb_terminal_input_conditioner;
    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] hh0_raw, hh1_raw;
    logic [1:0] b0_raw, b1_raw;
    logic       cmd_ack0, cmd_ack1;
    logic [3:0] hh0, hh1;
    logic [1:0] b0, b1;
    logic       cmd_valid0, cmd_valid1;

    terminal_input_conditioner #(
        .DEB_CYCLES    (DEB),
        .CNT_W         (3),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hh0_raw   (hh0_raw),
        .b0_raw    (b0_raw),
        .hh1_raw   (hh1_raw),
        .b1_raw    (b1_raw),
        .cmd_ack0  (cmd_ack0),
        .cmd_ack1  (cmd_ack1),
        .hh0       (hh0),
        .b0        (b0),
        .cmd_valid0(cmd_valid0),
        .hh1       (hh1),
        .b1        (b1),
        .cmd_valid1(cmd_valid1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic seen_v0, seen_v1;
    logic prev_v0, prev_v1;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounced bit flips once the last DEB synchronised samples (raw delayed by two
    // edges) all disagree with it. Commands: capture on a new press, hold until ack,
    // then stay quiet until every button of that terminal is up.
    logic [11:0] hist[$];
    logic [11:0] m_deb;
    logic [3:0]  m_prevb;
    logic [3:0]  m_hh [2];
    logic [1:0]  m_b [2];
    logic        m_valid [2];
    logic        m_wait_rel [2];
    logic [6:0]  exp_q[$];

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(12'h000);
        m_deb   = '0;
        m_prevb = '0;
        for (int t = 0; t < 2; t++) begin
            m_hh[t] = '0; m_b[t] = '0; m_valid[t] = 1'b0; m_wait_rel[t] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_clock();
        logic [11:0] raw_n;
        logic [1:0]  btn, prevb;
        logic [3:0]  hh_now;
        logic        ack_t, all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw_n = {~b1_raw, hh1_raw, ~b0_raw, hh0_raw};
        for (int t = 0; t < 2; t++) begin
            btn    = (t == 0) ? m_deb[5:4] : m_deb[11:10];
            prevb  = (t == 0) ? m_prevb[1:0] : m_prevb[3:2];
            hh_now = (t == 0) ? m_deb[3:0] : m_deb[9:6];
            ack_t  = (t == 0) ? cmd_ack0 : cmd_ack1;
            if (m_valid[t]) begin
                if (ack_t) begin
                    m_valid[t] = 1'b0; m_hh[t] = '0; m_b[t] = '0; m_wait_rel[t] = 1'b1;
                end
            end else if (m_wait_rel[t]) begin
                if (btn == 2'b00) m_wait_rel[t] = 1'b0;
            end else if ((btn & ~prevb) != 2'b00) begin
                m_valid[t] = 1'b1; m_hh[t] = hh_now; m_b[t] = btn;
                exp_q.push_back({t[0], hh_now, btn});
            end
        end
        m_prevb = {m_deb[11:10], m_deb[5:4]};
        for (int bi = 0; bi < 12; bi++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) begin
                if (hist[hist.size() - j][bi] == m_deb[bi]) all_diff = 1'b0;
            end
            if (all_diff) m_deb[bi] = ~m_deb[bi];
        end
        hist.push_back(raw_n);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic compare_and_score();
        logic [6:0] item;
        check("cycle", 16'({cmd_valid1, hh1, b1, cmd_valid0, hh0, b0}),
              16'({m_valid[1], m_hh[1], m_b[1], m_valid[0], m_hh[0], m_b[0]}));
        if (cmd_valid0 && !prev_v0) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL sb_t0: got cmd %h, expected none", {hh0, b0});
            end else begin
                item = exp_q.pop_front();
                check("sb_t0", 16'({1'b0, hh0, b0}), 16'(item));
            end
        end
        if (cmd_valid1 && !prev_v1) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL sb_t1: got cmd %h, expected none", {hh1, b1});
            end else begin
                item = exp_q.pop_front();
                check("sb_t1", 16'({1'b1, hh1, b1}), 16'(item));
            end
        end
        prev_v0 = cmd_valid0;
        prev_v1 = cmd_valid1;
        seen_v0 = seen_v0 | cmd_valid0;
        seen_v1 = seen_v1 | cmd_valid1;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare_and_score();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int t, input int max_cyc, output int n);
        logic v;
        n = 0;
        do begin
            step();
            n++;
            v = (t == 0) ? cmd_valid0 : cmd_valid1;
        end while (v !== 1'b1 && n < max_cyc);
        check((t == 0) ? "wait_valid0" : "wait_valid1", 16'(v), 16'h1);
    endtask

    task automatic ack_pulse(input logic a0, input logic a1);
        cmd_ack0 = a0; cmd_ack1 = a1;
        step();
        cmd_ack0 = 1'b0; cmd_ack1 = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  hh0;
        logic [1:0]  p0;
        logic [3:0]  hh1;
        logic [1:0]  p1;
        logic [13:0] exp_out;
    } vec_t;
    vec_t vecs [4];

    int n;

    initial begin
        vecs[0] = '{4'h3, 2'b01, 4'hC, 2'b00, {1'b0, 4'h0, 2'b00, 1'b1, 4'h3, 2'b01}};
        vecs[1] = '{4'h0, 2'b00, 4'h7, 2'b10, {1'b1, 4'h7, 2'b10, 1'b0, 4'h0, 2'b00}};
        vecs[2] = '{4'hF, 2'b11, 4'h1, 2'b11, {1'b1, 4'h1, 2'b11, 1'b1, 4'hF, 2'b11}};
        vecs[3] = '{4'h9, 2'b10, 4'h6, 2'b01, {1'b1, 4'h6, 2'b01, 1'b1, 4'h9, 2'b10}};

        rst_n = 1'b0; hh0_raw = '0; hh1_raw = '0; b0_raw = 2'b11; b1_raw = 2'b11;
        cmd_ack0 = 1'b0; cmd_ack1 = 1'b0;
        prev_v0 = 1'b0; prev_v1 = 1'b0; seen_v0 = 1'b0; seen_v1 = 1'b0;
        model_reset();

        // 1: reset with buttons idle, then 20 quiet cycles
        steps(3);
        check("t1_reset_outputs", 16'({cmd_valid1, hh1, b1, cmd_valid0, hh0, b0}), 16'h0);
        rst_n = 1'b1;
        seen_v0 = 1'b0; seen_v1 = 1'b0;
        steps(20);
        check("t1_no_valid", 16'({seen_v1, seen_v0}), 16'h0);

        // 2: bouncing button, exact latency after it settles
        hh0_raw = 4'b1011;
        steps(8);
        seen_v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b0_raw[0] = ~b0_raw[0];
            step();
        end
        check("t2_no_early_pulse", 16'(seen_v0), 16'h0);
        b0_raw[0] = 1'b0;
        wait_valid(0, 20, n);
        check("t2_latency", 16'(n - 1), 16'd6);
        check("t2_cmd", 16'({hh0, b0}), 16'({4'b1011, 2'b01}));

        // 3: frozen operands, ack turnaround, held button, second button
        hh0_raw = 4'b0000;
        steps(10);
        check("t3_frozen", 16'({cmd_valid0, hh0, b0}), 16'({1'b1, 4'b1011, 2'b01}));
        ack_pulse(1'b1, 1'b0);
        check("t3_ack_clear", 16'({cmd_valid0, hh0, b0}), 16'h0);
        seen_v0 = 1'b0;
        steps(10);
        check("t3_held_no_reissue", 16'(seen_v0), 16'h0);
        b0_raw = 2'b11;
        steps(10);
        b0_raw = 2'b01;
        wait_valid(0, 20, n);
        check("t3_second_button", 16'({hh0, b0}), 16'({4'b0000, 2'b10}));
        ack_pulse(1'b1, 1'b0);
        b0_raw = 2'b11;
        steps(10);

        // table-driven vectors
        for (int v = 0; v < 4; v++) begin
            hh0_raw = vecs[v].hh0; hh1_raw = vecs[v].hh1;
            steps(8);
            b0_raw = ~vecs[v].p0; b1_raw = ~vecs[v].p1;
            steps(8);
            check($sformatf("vec%0d", v),
                  16'({cmd_valid1, hh1, b1, cmd_valid0, hh0, b0}), 16'(vecs[v].exp_out));
            ack_pulse(1'b1, 1'b1);
            b0_raw = 2'b11; b1_raw = 2'b11;
            steps(10);
        end

        // 4: both terminals pressed together, independent acks
        hh0_raw = 4'h5; hh1_raw = 4'hA;
        steps(8);
        b0_raw = 2'b10; b1_raw = 2'b10;
        wait_valid(0, 20, n);
        check("t4_same_edge", 16'(cmd_valid1), 16'h1);
        check("t4_cmds", 16'({hh1, b1, hh0, b0}), 16'({4'hA, 2'b01, 4'h5, 2'b01}));
        steps(2);
        ack_pulse(1'b1, 1'b0);
        check("t4_ack0_only", 16'({cmd_valid1, cmd_valid0}), 16'b10);
        steps(3);
        ack_pulse(1'b0, 1'b1);
        check("t4_ack1", 16'({cmd_valid1, hh1, b1, cmd_valid0}), 16'h0);
        b0_raw = 2'b11; b1_raw = 2'b11;
        steps(10);

        // 5: short glitch on terminal 1, double press on terminal 0
        seen_v1 = 1'b0;
        b1_raw = 2'b10; b0_raw = 2'b00;
        steps(3);
        b1_raw = 2'b11;
        wait_valid(0, 20, n);
        check("t5_both_buttons", 16'({hh0, b0}), 16'({4'h5, 2'b11}));
        steps(10);
        check("t5_glitch_rejected", 16'(seen_v1), 16'h0);
        ack_pulse(1'b1, 1'b0);
        b0_raw = 2'b11;
        steps(10);

        // 6: asynchronous reset while a command is pending
        b0_raw = 2'b10;
        wait_valid(0, 20, n);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_reset", 16'({cmd_valid1, hh1, b1, cmd_valid0, hh0, b0}), 16'h0);
        b0_raw = 2'b11;
        steps(3);
        rst_n = 1'b1;
        seen_v0 = 1'b0; seen_v1 = 1'b0;
        steps(20);
        check("t6_no_spurious", 16'({seen_v1, seen_v0}), 16'h0);

        // random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            int sel;
            if ($urandom_range(0, 15) == 0) begin
                sel = $urandom_range(0, 1);
                b0_raw[sel] = ~b0_raw[sel];
            end
            if ($urandom_range(0, 15) == 0) begin
                sel = $urandom_range(0, 1);
                b1_raw[sel] = ~b1_raw[sel];
            end
            if ($urandom_range(0, 31) == 0) hh0_raw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) hh1_raw = 4'($urandom_range(0, 15));
            cmd_ack0 = ($urandom_range(0, 3) == 0);
            cmd_ack1 = ($urandom_range(0, 3) == 0);
            step();
        end
        cmd_ack0 = 1'b0; cmd_ack1 = 1'b0;
        step();
        check("sb_drain", 16'(exp_q.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
